key_scanner: RTL

KEY_SCANNER -- requirements
Module: key_scanner

---
 rtl/key_scanner.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/key_scanner.sv
// key_scanner: 4x4 matrix keypad scanner with per-frame debouncing.
// Rows are driven active-low one at a time. Columns are synchronised and
// sampled once per row slot. Four row samples form one frame. A debounce
// state machine turns the frame stream into press/release/replace events.
module key_scanner #(
    parameter int SCAN_DIV       = 10_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_press,
    output logic       key_release
);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    localparam logic [16:0] DIV_LAST = 17'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB_N    = 4'(DEBOUNCE_SCANS);

    // Column synchroniser. It resets to all-ones (no key), which is the
    // idle level of the pulled-up lines, so a short scan slot right after
    // reset never sees a phantom key.
    logic [3:0] col_meta_reg;
    logic [3:0] col_sync_reg;

    // Scan timing and row selection
    logic [16:0] div_reg;
    logic [1:0]  row_idx_reg;
    logic        tick;
    logic        frame_valid;

    // Per-frame accumulation of the lowest pressed key seen so far
    logic        acc_hit_reg;
    logic [3:0]  acc_code_reg;
    logic        row_hit;
    logic [1:0]  row_col;
    logic        frame_hit;
    logic [3:0]  frame_code;

    // Debounce state machine
    state_t      state_reg, state_next;
    logic        cand_hit_reg, cand_hit_next;
    logic [3:0]  cand_code_reg, cand_code_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [3:0]  cnt_inc;
    logic [3:0]  new_cnt;
    logic        same_cand;
    logic [3:0]  key_code_reg, key_code_next;
    logic        key_valid_reg, key_valid_next;
    logic        key_press_reg, key_press_next;
    logic        key_release_reg, key_release_next;

    // Two-flop synchroniser on the raw column lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta_reg <= 4'hF;
            col_sync_reg <= 4'hF;
        end else begin
            col_meta_reg <= col;
            col_sync_reg <= col_meta_reg;
        end
    end

    assign tick        = (div_reg == DIV_LAST);
    assign frame_valid = tick && (row_idx_reg == 2'd3);

    // Slot divider and row index; the row advances on each tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg     <= '0;
            row_idx_reg <= 2'd0;
        end else if (tick) begin
            div_reg     <= '0;
            row_idx_reg <= row_idx_reg + 2'd1;
        end else begin
            div_reg <= div_reg + 17'd1;
        end
    end

    // Exactly one row line driven low: the one matching the row index
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row_drive
            assign row[gi] = (row_idx_reg != 2'(gi));
        end
    endgenerate

    // Lowest low column in the current row. Scanning downward leaves the
    // lowest index as the final assignment.
    always_comb begin
        row_hit = 1'b0;
        row_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_sync_reg[c]) begin
                row_hit = 1'b1;
                row_col = 2'(c);
            end
        end
    end

    // Keep the first (lowest-index) hit of the frame. Row 0 restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_hit_reg  <= 1'b0;
            acc_code_reg <= 4'd0;
        end else if (tick) begin
            if (row_idx_reg == 2'd0) begin
                acc_hit_reg  <= row_hit;
                acc_code_reg <= {2'd0, row_col};
            end else if (!acc_hit_reg && row_hit) begin
                acc_hit_reg  <= 1'b1;
                acc_code_reg <= {row_idx_reg, row_col};
            end
        end
    end

    // Frame result at the row-3 tick: rows 0..2 take priority over row 3
    assign frame_hit  = acc_hit_reg | row_hit;
    assign frame_code = acc_hit_reg ? acc_code_reg : {row_idx_reg, row_col};

    // Saturating increment of the match count
    assign cnt_inc = (cnt_reg == 4'hF) ? 4'hF : (cnt_reg + 4'd1);

    // Debounce state and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            cand_hit_reg    <= 1'b0;
            cand_code_reg   <= 4'd0;
            cnt_reg         <= 4'd0;
            key_code_reg    <= 4'd0;
            key_valid_reg   <= 1'b0;
            key_press_reg   <= 1'b0;
            key_release_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cand_hit_reg    <= cand_hit_next;
            cand_code_reg   <= cand_code_next;
            cnt_reg         <= cnt_next;
            key_code_reg    <= key_code_next;
            key_valid_reg   <= key_valid_next;
            key_press_reg   <= key_press_next;
            key_release_reg <= key_release_next;
        end
    end

    // Next-state logic: evaluated only when a frame completes
    always_comb begin
        state_next       = state_reg;
        cand_hit_next    = cand_hit_reg;
        cand_code_next   = cand_code_reg;
        cnt_next         = cnt_reg;
        key_code_next    = key_code_reg;
        key_valid_next   = key_valid_reg;
        key_press_next   = 1'b0;
        key_release_next = 1'b0;
        new_cnt          = 4'd0;
        same_cand        = 1'b0;

        if (frame_valid) begin
            case (state_reg)
                IDLE, DEB_PRESS: begin
                    if (!frame_hit) begin
                        state_next    = IDLE;
                        cand_hit_next = 1'b0;
                        cnt_next      = 4'd0;
                    end else begin
                        same_cand = (state_reg == DEB_PRESS) &&
                                    (frame_code == cand_code_reg);
                        new_cnt   = same_cand ? cnt_inc : 4'd1;
                        cand_hit_next  = 1'b1;
                        cand_code_next = frame_code;
                        if (new_cnt >= DEB_N) begin
                            state_next     = HELD;
                            cnt_next       = 4'd0;
                            key_code_next  = frame_code;
                            key_valid_next = 1'b1;
                            key_press_next = 1'b1;
                        end else begin
                            state_next = DEB_PRESS;
                            cnt_next   = new_cnt;
                        end
                    end
                end

                HELD, DEB_RELEASE: begin
                    if (frame_hit && (frame_code == key_code_reg)) begin
                        // The held key is back (or never left): no event
                        state_next = HELD;
                        cnt_next   = 4'd0;
                    end else begin
                        same_cand = (state_reg == DEB_RELEASE) &&
                                    (frame_hit == cand_hit_reg) &&
                                    (!frame_hit || (frame_code == cand_code_reg));
                        new_cnt   = same_cand ? cnt_inc : 4'd1;
                        cand_hit_next  = frame_hit;
                        cand_code_next = frame_code;
                        if (new_cnt >= DEB_N) begin
                            cnt_next         = 4'd0;
                            key_release_next = 1'b1;
                            if (!frame_hit) begin
                                // Released: code keeps its last value
                                state_next     = IDLE;
                                key_valid_next = 1'b0;
                            end else begin
                                // Replaced by another key without dropping valid
                                state_next     = HELD;
                                key_code_next  = frame_code;
                                key_press_next = 1'b1;
                            end
                        end else begin
                            state_next = DEB_RELEASE;
                            cnt_next   = new_cnt;
                        end
                    end
                end

                default: begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    assign key_code    = key_code_reg;
    assign key_valid   = key_valid_reg;
    assign key_press   = key_press_reg;
    assign key_release = key_release_reg;

endmodule
